// File: rtl/pipeline_control_unit_pkg.sv
`timescale 1ns/1ps
// Opcode values, FSM encoding and delay-line entry layout shared by the pipeline
// control unit and the datapath decoder.
package pipeline_control_unit_pkg;

  localparam logic [3:0] OP_LDM   = 4'b0000;
  localparam logic [3:0] OP_STM   = 4'b0001;
  localparam logic [3:0] OP_LDR   = 4'b0010;
  localparam logic [3:0] OP_MOV   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_NOT   = 4'b0111;
  localparam logic [3:0] OP_SHL   = 4'b1000;
  localparam logic [3:0] OP_SHR   = 4'b1001;
  localparam logic [3:0] OP_ADD   = 4'b1010;
  localparam logic [3:0] OP_SUB   = 4'b1011;
  localparam logic [3:0] OP_DIV   = 4'b1100;
  localparam logic [3:0] OP_ILL_A = 4'b1101;
  localparam logic [3:0] OP_ILL_B = 4'b1110;
  localparam logic [3:0] OP_HLT   = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic mem_we;
    logic reg_we;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Bits dropped from the EX entry when an ALU error squashes it.
  localparam entry_t SQUASH_MASK = '{valid: 1'b0, mem_we: 1'b0, reg_we: 1'b1};

  function automatic entry_t decode_opcode(input logic [3:0] op);
    entry_t e;
    e = '0;
    case (op)
      OP_STM: begin
        e.valid  = 1'b1;
        e.mem_we = 1'b1;
      end
      OP_HLT: e.valid = 1'b1;
      OP_LDM, OP_LDR, OP_MOV, OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_SHL, OP_SHR, OP_ADD, OP_SUB, OP_DIV: begin
        e.valid  = 1'b1;
        e.reg_we = 1'b1;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == OP_ILL_A) || (op == OP_ILL_B);
  endfunction

endpackage

// File: rtl/pipeline_control_unit_delay_line.sv
`timescale 1ns/1ps
// Shift register of per-instruction control entries; i_clr_entry[i] strips
// i_clr_bits from the value being written into position i on this edge.
module pipeline_control_unit_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            i_data,
  input  logic [DEPTH-1:0]            i_clr_entry,
  input  logic [WIDTH-1:0]            i_clr_bits,
  output logic [DEPTH-1:0][WIDTH-1:0] o_line
);

  logic [DEPTH-1:0][WIDTH-1:0] r_entry;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_entry <= '0;
    end else begin
      r_entry[0] <= i_clr_entry[0] ? (i_data & ~i_clr_bits) : i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_entry[i] <= i_clr_entry[i] ? (r_entry[i-1] & ~i_clr_bits) : r_entry[i-1];
      end
    end
  end

  assign o_line = r_entry;

endmodule

// File: rtl/pipeline_control_unit.sv
`timescale 1ns/1ps
// Upstream control for the 5-stage datapath: opcode decode, write-enable delay line,
// halt/drain FSM, sticky status and retired-instruction counter.
// RUN: issuing | DRAIN: in-flight entries finishing | HALTED: frozen until reset
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int MEM_DELAY = 2,
  parameter int WB_DELAY  = 3,
  parameter bit ERR_HALT  = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       i_opcode,
  input  logic             i_zero_flag,
  input  logic             i_error_flag,
  output logic             o_mem_signal_write,
  output logic             o_reg_signal_write,
  output logic             o_pc_hold,
  output logic             o_halted,
  output logic             o_illegal_opcode,
  output logic             o_error_sticky,
  output logic             o_last_zero,
  output logic [CNT_W-1:0] o_retired_count
);

  localparam logic [2:0] DRAIN_LOAD = 3'(WB_DELAY);

  state_t                           r_state;
  state_t                           w_state_next;
  logic [2:0]                       r_drain_cnt;
  logic [2:0]                       w_drain_cnt_next;
  logic                             w_hold;
  logic                             w_halted;
  logic                             w_run;
  entry_t                           w_load;
  entry_t                           w_ex;
  entry_t                           w_mem_slot;
  entry_t                           w_wb_slot;
  logic [WB_DELAY-1:0][ENTRY_W-1:0] w_line;
  logic [WB_DELAY-1:0]              w_clr_entry;
  logic                             w_err_seen;
  logic                             w_squash;
  logic                             w_hlt;
  logic                             w_unused;
  logic                             r_illegal;
  logic                             r_error;
  logic                             r_zero;
  logic [CNT_W-1:0]                 r_retired;

  assign w_run      = (r_state == ST_RUN);
  assign w_load     = w_run ? decode_opcode(i_opcode) : '0;
  assign w_ex       = w_line[0];
  assign w_mem_slot = w_line[MEM_DELAY-1];
  assign w_wb_slot  = w_line[WB_DELAY-1];
  assign w_err_seen = i_error_flag & w_ex.valid;
  assign w_squash   = ERR_HALT && w_err_seen && w_run;
  assign w_hlt      = w_run && (i_opcode == OP_HLT);
  assign w_unused   = ^w_line;

  // The squashed EX entry is moving from position 0 into position 1 on this edge.
  always_comb begin
    w_clr_entry    = '0;
    w_clr_entry[1] = w_squash;
  end

  pipeline_control_unit_delay_line #(
    .DEPTH(WB_DELAY),
    .WIDTH(ENTRY_W)
  ) u_delay_line (
    .clock      (clock),
    .reset      (reset),
    .i_data     (w_load),
    .i_clr_entry(w_clr_entry),
    .i_clr_bits (SQUASH_MASK),
    .o_line     (w_line)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_drain_cnt_next = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_hlt || w_squash) begin
          w_state_next     = ST_DRAIN;
          w_drain_cnt_next = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        w_drain_cnt_next = r_drain_cnt - 3'd1;
        if (r_drain_cnt == 3'd1) w_state_next = ST_HALTED;
      end
      ST_HALTED: w_state_next = ST_HALTED;
      default:   w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_hold   = 1'b1;
    w_halted = 1'b0;
    case (r_state)
      ST_RUN:    w_hold   = 1'b0;
      ST_HALTED: w_halted = 1'b1;
      default:   w_hold   = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_illegal <= 1'b0;
      r_error   <= 1'b0;
      r_zero    <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_run && is_illegal(i_opcode)) r_illegal <= 1'b1;
      if (w_err_seen) r_error <= 1'b1;
      if (w_ex.valid) r_zero <= i_zero_flag;
      if (w_wb_slot.valid) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign o_mem_signal_write = w_mem_slot.valid & w_mem_slot.mem_we & ~w_halted;
  assign o_reg_signal_write = w_wb_slot.valid & w_wb_slot.reg_we & ~w_halted;
  assign o_pc_hold          = w_hold;
  assign o_halted           = w_halted;
  assign o_illegal_opcode   = r_illegal;
  assign o_error_sticky     = r_error;
  assign o_last_zero        = r_zero;
  assign o_retired_count    = r_retired;

endmodule

// File: tb/tb_pipeline_control_unit.sv
`timescale 1ns/1ps
// Self-checking bench for pipeline_control_unit: directed scenarios plus randomized
// traffic compared against an issue-history reference model.
module tb_pipeline_control_unit;

  localparam int MEM_DELAY = 2;
  localparam int WB_DELAY  = 3;
  localparam bit ERR_HALT  = 1'b1;
  localparam int CNT_W     = 16;

  localparam logic [3:0] STM = 4'b0001;
  localparam logic [3:0] LDR = 4'b0010;
  localparam logic [3:0] ADD = 4'b1010;
  localparam logic [3:0] DIV = 4'b1100;
  localparam logic [3:0] ILA = 4'b1101;
  localparam logic [3:0] ILB = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;

  logic             clock = 1'b0;
  logic             reset;
  logic [3:0]       opcode;
  logic             zero_flag;
  logic             error_flag;
  logic             mem_w;
  logic             reg_w;
  logic             pc_hold;
  logic             halted;
  logic             illegal;
  logic             err_st;
  logic             last_zero;
  logic [CNT_W-1:0] retired;

  pipeline_control_unit #(
    .MEM_DELAY(MEM_DELAY),
    .WB_DELAY (WB_DELAY),
    .ERR_HALT (ERR_HALT),
    .CNT_W    (CNT_W)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .i_opcode          (opcode),
    .i_zero_flag       (zero_flag),
    .i_error_flag      (error_flag),
    .o_mem_signal_write(mem_w),
    .o_reg_signal_write(reg_w),
    .o_pc_hold         (pc_hold),
    .o_halted          (halted),
    .o_illegal_opcode  (illegal),
    .o_error_sticky    (err_st),
    .o_last_zero       (last_zero),
    .o_retired_count   (retired)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what was issued at each edge since reset, plus the edge at
  // which the unit stopped issuing. Outputs follow from edge arithmetic.
  typedef struct packed {
    bit valid;
    bit mem;
    bit rg;
  } issue_t;

  issue_t           issued [8];
  int               edge_n;
  int               hold_edge;
  bit               m_ill;
  bit               m_err;
  bit               m_zero;
  logic [CNT_W-1:0] m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) issued[i] = '{1'b0, 1'b0, 1'b0};
    edge_n    = 0;
    hold_edge = -1;
    m_ill     = 1'b0;
    m_err     = 1'b0;
    m_zero    = 1'b0;
    m_cnt     = '0;
  endtask

  function automatic bit exp_mem();
    issue_t s;
    s = issued[(edge_n - MEM_DELAY + 1) & 7];
    return s.valid & s.mem;
  endfunction

  function automatic bit exp_reg();
    issue_t s;
    s = issued[(edge_n - WB_DELAY + 1) & 7];
    return s.valid & s.rg;
  endfunction

  function automatic bit exp_hold();
    return hold_edge >= 0;
  endfunction

  function automatic bit exp_halted();
    return (hold_edge >= 0) && (edge_n >= hold_edge + WB_DELAY);
  endfunction

  task automatic tick(input logic [3:0] op, input bit zf, input bit ef);
    issue_t ex;
    issue_t nw;
    bit     run;
    opcode     = op;
    zero_flag  = zf;
    error_flag = ef;
    @(posedge clock);
    edge_n++;
    run = (hold_edge < 0);
    ex  = issued[(edge_n - 1) & 7];
    if (ex.valid) begin
      m_zero = zf;
      if (ef) m_err = 1'b1;
      if (ef && ERR_HALT && run) begin
        issued[(edge_n - 1) & 7].rg = 1'b0;
        hold_edge = edge_n;
      end
    end
    if (issued[(edge_n - WB_DELAY) & 7].valid) m_cnt++;
    nw = '{1'b0, 1'b0, 1'b0};
    if (run) begin
      if (op == ILA || op == ILB) m_ill = 1'b1;
      else if (op == HLT) begin
        nw        = '{1'b1, 1'b0, 1'b0};
        hold_edge = edge_n;
      end
      else if (op == STM) nw = '{1'b1, 1'b1, 1'b0};
      else nw = '{1'b1, 1'b0, 1'b1};
    end
    issued[edge_n & 7] = nw;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    opcode     = ADD;
    zero_flag  = 1'b1;
    error_flag = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if ({mem_w, reg_w, pc_hold, halted, illegal, err_st, last_zero, retired} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b %b %b %b %b %b %b %h, want all 0",
               mem_w, reg_w, pc_hold, halted, illegal, err_st, last_zero, retired);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_add();
    bit exp_r [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int e = 1; e <= 4; e++) begin
      tick((e == 1) ? ADD : ILB, 1'b0, 1'b0);
      n_checks++;
      if (reg_w !== exp_r[e-1] || mem_w !== 1'b0) begin
        n_errors++;
        $display("FAIL add_writes edge %0d: reg=%b mem=%b, want reg=%b mem=0",
                 e, reg_w, mem_w, exp_r[e-1]);
      end
    end
    n_checks++;
    if (retired !== 16'd1) begin
      n_errors++;
      $display("FAIL add_retired: got %0d want 1", retired);
    end
  endtask

  task automatic test_stm();
    bit exp_m [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int e = 1; e <= 4; e++) begin
      tick((e == 1) ? STM : ILA, 1'b0, 1'b0);
      n_checks++;
      if (mem_w !== exp_m[e-1] || reg_w !== 1'b0) begin
        n_errors++;
        $display("FAIL stm_writes edge %0d: mem=%b reg=%b, want mem=%b reg=0",
                 e, mem_w, reg_w, exp_m[e-1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops   [7] = '{LDR, ADD, HLT, ADD, ADD, ADD, ADD};
    bit         exp_r [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bit         exp_p [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit         exp_h [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int e = 1; e <= 7; e++) begin
      tick(ops[e-1], 1'b0, 1'b0);
      n_checks++;
      if (reg_w !== exp_r[e-1] || pc_hold !== exp_p[e-1] || halted !== exp_h[e-1]) begin
        n_errors++;
        $display("FAIL b2b edge %0d: reg=%b pc_hold=%b halted=%b, want %b %b %b",
                 e, reg_w, pc_hold, halted, exp_r[e-1], exp_p[e-1], exp_h[e-1]);
      end
    end
    n_checks++;
    if (retired !== 16'd3) begin
      n_errors++;
      $display("FAIL b2b_retired: got %0d want 3", retired);
    end
  endtask

  task automatic test_div_error();
    bit exp_h [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int e = 1; e <= 5; e++) begin
      tick((e == 1) ? DIV : ((e == 2) ? ILA : ADD), 1'b0, e == 2);
      n_checks++;
      if (reg_w !== 1'b0 || halted !== exp_h[e-1] || pc_hold !== (e >= 2)) begin
        n_errors++;
        $display("FAIL div_err edge %0d: reg=%b halted=%b pc_hold=%b, want 0 %b %b",
                 e, reg_w, halted, pc_hold, exp_h[e-1], e >= 2);
      end
    end
    n_checks++;
    if (err_st !== 1'b1) begin
      n_errors++;
      $display("FAIL div_err_sticky: got %b want 1", err_st);
    end
  endtask

  task automatic test_err_and_hlt();
    do_reset();
    tick(DIV, 1'b0, 1'b0);
    tick(HLT, 1'b0, 1'b1);
    n_checks++;
    if (pc_hold !== 1'b1 || err_st !== 1'b1) begin
      n_errors++;
      $display("FAIL err_hlt_e2: pc_hold=%b err=%b, want 1 1", pc_hold, err_st);
    end
    for (int e = 3; e <= 5; e++) begin
      tick(ADD, 1'b0, 1'b0);
      n_checks++;
      if (reg_w !== 1'b0 || halted !== (e == 5)) begin
        n_errors++;
        $display("FAIL err_hlt edge %0d: reg=%b halted=%b, want 0 %b", e, reg_w, halted, e == 5);
      end
    end
    n_checks++;
    if (retired !== 16'd2) begin
      n_errors++;
      $display("FAIL err_hlt_retired: got %0d want 2", retired);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    for (int e = 1; e <= 4; e++) begin
      tick((e == 1) ? ILA : ILB, 1'b0, 1'b0);
      n_checks++;
      if (illegal !== 1'b1 || mem_w !== 1'b0 || reg_w !== 1'b0 || retired !== 16'd0) begin
        n_errors++;
        $display("FAIL illegal edge %0d: ill=%b mem=%b reg=%b cnt=%0d, want 1 0 0 0",
                 e, illegal, mem_w, reg_w, retired);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int e = 1; e <= 65538; e++) tick(LDR, 1'b0, 1'b0);
    n_checks++;
    if (retired !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL wrap_full: got %h want ffff", retired);
    end
    tick(LDR, 1'b0, 1'b0);
    n_checks++;
    if (retired !== 16'h0000) begin
      n_errors++;
      $display("FAIL wrap_zero: got %h want 0000", retired);
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    tick(LDR, 1'b0, 1'b0);
    tick(ILA, 1'b1, 1'b0);
    tick(HLT, 1'b0, 1'b0);
    tick(ADD, 1'b1, 1'b1);
    n_checks++;
    if ({pc_hold, halted, illegal, err_st, last_zero} !== 5'b10111 || retired !== 16'd1) begin
      n_errors++;
      $display("FAIL drain_before_reset: hold/halt/ill/err/zero=%b%b%b%b%b cnt=%0d, want 10111 1",
               pc_hold, halted, illegal, err_st, last_zero, retired);
    end
    do_reset();
    n_checks++;
    if ({mem_w, reg_w, pc_hold, halted, illegal, err_st, last_zero, retired} !== '0) begin
      n_errors++;
      $display("FAIL drain_reset_outputs: got %b %b %b %b %b %b %b %h, want all 0",
               mem_w, reg_w, pc_hold, halted, illegal, err_st, last_zero, retired);
    end
    tick(ADD, 1'b0, 1'b0);
    tick(ILB, 1'b0, 1'b0);
    tick(ILB, 1'b0, 1'b0);
    n_checks++;
    if (pc_hold !== 1'b0 || reg_w !== 1'b1) begin
      n_errors++;
      $display("FAIL drain_reset_run: pc_hold=%b reg=%b, want 0 1", pc_hold, reg_w);
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      int         r;
      logic [3:0] op;
      r = $urandom_range(0, 99);
      if (r < 4) op = HLT;
      else if (r < 8) op = ($urandom_range(0, 1) != 0) ? ILA : ILB;
      else op = 4'($urandom_range(0, 12));
      if ((exp_halted() && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
        n_checks++;
        if ({mem_w, reg_w, pc_hold, halted, illegal, err_st, last_zero, retired} !== '0) begin
          n_errors++;
          $display("FAIL rand_reset iter %0d: outputs not cleared", i);
        end
      end else begin
        tick(op, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 6);
        n_checks++;
        if (mem_w !== exp_mem() || reg_w !== exp_reg() ||
            pc_hold !== exp_hold() || halted !== exp_halted()) begin
          n_errors++;
          $display("FAIL rand_ctrl iter %0d: mem/reg/hold/halt=%b%b%b%b want %b%b%b%b",
                   i, mem_w, reg_w, pc_hold, halted,
                   exp_mem(), exp_reg(), exp_hold(), exp_halted());
        end
        n_checks++;
        if (illegal !== m_ill || err_st !== m_err || last_zero !== m_zero || retired !== m_cnt) begin
          n_errors++;
          $display("FAIL rand_status iter %0d: ill/err/zero=%b%b%b cnt=%0d want %b%b%b cnt=%0d",
                   i, illegal, err_st, last_zero, retired, m_ill, m_err, m_zero, m_cnt);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_add();
    test_stm();
    test_back_to_back();
    test_div_error();
    test_err_and_hlt();
    test_illegal();
    test_reset_in_drain();
    test_random(3000);
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
